// File: rtl/lenet_pkg.sv
// lenet_pkg: shared constants, FSM encoding and SRAM lane extraction for the LeNet pipeline
package lenet_pkg;
  localparam int CLASS_NUM = 10;
  localparam int LANE_W = 8;
  localparam int LANES = 4;
  typedef enum logic [2:0] {S_IDLE = 3'd0, S_FETCH = 3'd1, S_LATCH = 3'd2, S_SCAN = 3'd3, S_OUT = 3'd4} state_e;
  // Lane 0 is the most significant byte, matching FC bytemask order 1000->0001.
  function automatic logic signed [LANE_W-1:0] lane_score(input logic [LANE_W*LANES-1:0] word, input logic [1:0] lane);
    return word[LANE_W*LANES-1-LANE_W*lane -: LANE_W];
  endfunction
endpackage

// File: rtl/argmax_cmp.sv
// argmax_cmp: registered running maximum with unconditional load and signed strict-greater update
module argmax_cmp #(
  parameter int DW = 8,
  parameter int IW = 4
) (
  input  logic                 clk,
  input  logic                 srst,
  input  logic                 en,
  input  logic                 load,
  input  logic signed [DW-1:0] in_score,
  input  logic        [IW-1:0] in_idx,
  output logic signed [DW-1:0] nxt_score,
  output logic        [IW-1:0] nxt_idx
);
  logic signed [DW-1:0] max_score_q;
  logic        [IW-1:0] max_idx_q;
  logic                 take;
  always_comb begin
    take = en && (load || in_score > max_score_q);
    nxt_score = take ? in_score : max_score_q;
    nxt_idx = take ? in_idx : max_idx_q;
  end
  always_ff @(posedge clk) begin
    if (srst) begin
      max_score_q <= '0;
      max_idx_q <= '0;
    end else begin
      max_score_q <= nxt_score;
      max_idx_q <= nxt_idx;
    end
  end
endmodule

// File: rtl/fc_argmax.sv
// fc_argmax: sequential argmax over the ten FC2 scores in SRAM f with a valid/ready result port
module fc_argmax #(
  parameter int DATA_WIDTH = 8,
  parameter int DATA_NUM_PER_SRAM_ADDR = 4,
  parameter int CLASS_NUM = 10,
  parameter int F_ADDR_WIDTH = 6
) (
  input  logic                                         clk,
  input  logic                                         srst,
  input  logic                                         fc2_done,
  output logic [F_ADDR_WIDTH-1:0]                      sram_raddr_f,
  input  logic [DATA_WIDTH*DATA_NUM_PER_SRAM_ADDR-1:0] sram_rdata_f,
  output logic                                         result_valid,
  input  logic                                         result_ready,
  output logic [3:0]                                   result_class,
  output logic [DATA_WIDTH-1:0]                        result_score,
  output logic                                         busy
);
  import lenet_pkg::*;
  state_e state_q, state_d;
  logic [1:0] word_cnt_q, word_cnt_d, lane_cnt_q, lane_cnt_d;
  logic [3:0] class_cnt_q, class_cnt_d;
  logic pending_q, pending_d;
  logic [DATA_WIDTH*DATA_NUM_PER_SRAM_ADDR-1:0] word_buf_q, word_buf_d;
  logic [3:0] result_class_q, result_class_d;
  logic [DATA_WIDTH-1:0] result_score_q, result_score_d;
  logic signed [DATA_WIDTH-1:0] nxt_score;
  logic [3:0] nxt_idx;
  logic start, scan, last_class;
  assign start = fc2_done || pending_q;
  assign scan = state_q == S_SCAN;
  assign last_class = class_cnt_q == 4'(CLASS_NUM - 1);
  argmax_cmp #(.DW(DATA_WIDTH), .IW(4)) u_cmp (
    .clk(clk), .srst(srst), .en(scan), .load(class_cnt_q == 4'd0),
    .in_score(lane_score(word_buf_q, lane_cnt_q)), .in_idx(class_cnt_q),
    .nxt_score(nxt_score), .nxt_idx(nxt_idx)
  );
  always_comb begin
    state_d = state_q;
    word_cnt_d = word_cnt_q;
    lane_cnt_d = lane_cnt_q;
    class_cnt_d = class_cnt_q;
    word_buf_d = word_buf_q;
    pending_d = pending_q || (fc2_done && state_q != S_IDLE);
    result_class_d = scan && last_class ? nxt_idx : result_class_q;
    result_score_d = scan && last_class ? nxt_score : result_score_q;
    case (state_q)
      S_IDLE: state_d = start ? S_FETCH : S_IDLE;
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        word_buf_d = sram_rdata_f;
        state_d = S_SCAN;
      end
      S_SCAN: begin
        class_cnt_d = class_cnt_q + 4'd1;
        lane_cnt_d = lane_cnt_q + 2'd1;
        if (last_class) state_d = S_OUT;
        else if (lane_cnt_q == 2'd3) begin
          word_cnt_d = word_cnt_q + 2'd1;
          state_d = S_FETCH;
        end
      end
      // A pending request restarts straight from the handshake cycle.
      S_OUT: state_d = result_ready ? (start ? S_FETCH : S_IDLE) : S_OUT;
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_FETCH && (state_q == S_IDLE || state_q == S_OUT)) begin
      pending_d = 1'b0;
      word_cnt_d = '0;
      lane_cnt_d = '0;
      class_cnt_d = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q <= S_IDLE;
      word_cnt_q <= '0;
      lane_cnt_q <= '0;
      class_cnt_q <= '0;
      pending_q <= 1'b0;
      word_buf_q <= '0;
      result_class_q <= '0;
      result_score_q <= '0;
    end else begin
      state_q <= state_d;
      word_cnt_q <= word_cnt_d;
      lane_cnt_q <= lane_cnt_d;
      class_cnt_q <= class_cnt_d;
      pending_q <= pending_d;
      word_buf_q <= word_buf_d;
      result_class_q <= result_class_d;
      result_score_q <= result_score_d;
    end
  end
  assign sram_raddr_f = F_ADDR_WIDTH'(word_cnt_q);
  assign result_valid = state_q == S_OUT;
  assign result_class = result_class_q;
  assign result_score = result_score_q;
  assign busy = state_q != S_IDLE;
endmodule

// File: tb/tb_fc_argmax.sv
// tb_fc_argmax: directed-vector bench for fc_argmax with a 1-cycle-latency SRAM f model
module tb_fc_argmax;
  logic clk = 1'b0, srst, fc2_done, result_valid, result_ready, busy;
  logic [5:0] sram_raddr_f;
  logic [31:0] sram_rdata_f;
  logic [3:0] result_class;
  logic [7:0] result_score;
  logic [31:0] mem [0:63];
  int s [10];
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  always_ff @(posedge clk) sram_rdata_f <= mem[sram_raddr_f];
  fc_argmax dut (
    .clk(clk), .srst(srst), .fc2_done(fc2_done), .sram_raddr_f(sram_raddr_f),
    .sram_rdata_f(sram_rdata_f), .result_valid(result_valid), .result_ready(result_ready),
    .result_class(result_class), .result_score(result_score), .busy(busy)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic set_mem(input int j2, input int j3);
    int a [12];
    for (int i = 0; i < 10; i++) a[i] = s[i];
    a[10] = j2;
    a[11] = j3;
    for (int w = 0; w < 3; w++) mem[w] = {8'(a[4*w]), 8'(a[4*w+1]), 8'(a[4*w+2]), 8'(a[4*w+3])};
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic scan(output int lat);
    fc2_done = 1'b1;
    tick();
    fc2_done = 1'b0;
    lat = 1;
    while (!result_valid && lat < 100) begin
      tick();
      lat++;
    end
  endtask
  task automatic accept;
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
  endtask
  initial begin
    int lat;
    logic seen;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    srst = 1'b1;
    fc2_done = 1'b0;
    result_ready = 1'b0;
    repeat (3) tick();
    srst = 1'b0;
    chk("rst_valid", result_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_class", result_class, 0);
    chk("rst_score", result_score, 0);
    chk("rst_raddr", sram_raddr_f, 0);
    s = '{3, -5, 7, 2, 9, 1, 0, -1, 4, 6};
    set_mem(0, 0);
    scan(lat);
    chk("t1_latency", lat, 17);
    chk("t1_class", result_class, 4);
    chk("t1_score", result_score, 9);
    accept();
    chk("t1_valid_drop", result_valid, 0);
    chk("t1_idle", busy, 0);
    s = '{-128, -128, -128, -128, -128, -128, -128, -128, -128, -128};
    set_mem(-128, -128);
    scan(lat);
    chk("tie_latency", lat, 17);
    chk("tie_class", result_class, 0);
    chk("tie_score", result_score, 8'h80);
    accept();
    s = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 127};
    set_mem(127, 127);
    scan(lat);
    chk("c9_class", result_class, 9);
    chk("c9_score", result_score, 127);
    accept();
    s[9] = 0;
    set_mem(127, 127);
    scan(lat);
    chk("junk_class", result_class, 8);
    chk("junk_score", result_score, 9);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!result_valid || result_class != 4'd8 || result_score != 8'd9) seen = 1'b1;
      tick();
    end
    chk("hold_unstable", seen, 0);
    chk("hold_valid", result_valid, 1);
    accept();
    chk("hold_drop", result_valid, 0);
    fc2_done = 1'b1;
    tick();
    fc2_done = 1'b0;
    for (int c = 1; c < 10; c++) begin
      fc2_done = c == 5;
      tick();
    end
    fc2_done = 1'b0;
    srst = 1'b1;
    tick();
    srst = 1'b0;
    chk("srst_busy", busy, 0);
    chk("srst_valid", result_valid, 0);
    chk("srst_class", result_class, 0);
    chk("srst_score", result_score, 0);
    chk("srst_raddr", sram_raddr_f, 0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (busy || result_valid) seen = 1'b1;
      tick();
    end
    chk("srst_pending_cleared", seen, 0);
    srst = 1'b1;
    fc2_done = 1'b1;
    tick();
    srst = 1'b0;
    fc2_done = 1'b0;
    tick();
    chk("srst_priority", busy, 0);
    s = '{3, -5, 7, 2, 9, 1, 0, -1, 4, 6};
    set_mem(0, 0);
    fc2_done = 1'b1;
    tick();
    lat = 1;
    while (!result_valid && lat < 100) begin
      fc2_done = lat == 5 || lat == 9;
      tick();
      lat++;
    end
    fc2_done = 1'b0;
    chk("pend_first_class", result_class, 4);
    s = '{-7, 50, 50, 12, -1, 0, 49, 3, 2, 1};
    set_mem(100, 100);
    accept();
    chk("pend_restart_busy", busy, 1);
    chk("pend_restart_valid", result_valid, 0);
    lat = 1;
    while (!result_valid && lat < 100) begin
      tick();
      lat++;
    end
    chk("pend_latency", lat, 17);
    chk("pend_class", result_class, 1);
    chk("pend_score", result_score, 50);
    accept();
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (busy) seen = 1'b1;
      tick();
    end
    chk("pend_single_rescan", seen, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
